md_sched: RTL

Multiply/divide unit scheduler for the five-stage pipeline. It owns the HI/LO registers and sequences MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, and it executes MTHI/MTLO in one cycle. It sits beside the Execution stage: the E stage issues `start` with an opcode and operands, and the block returns `busy`. It also returns a combinational `stall_req` that the hazard unit ORs into its stall for any MD-class instruction waiting in Decode.

---
 rtl/md_sched_if.sv | 25 ++
 rtl/md_sched.sv | 116 +++++++++++
 2 files changed

// File: rtl/md_sched_if.sv
// md_sched_if: E-stage <-> multiply/divide scheduler bundle.
// master = E stage/hazard side, slave = md_sched.
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        d_is_md;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, flush, d_is_md,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, d_is_md,
    output busy, stall_req, done, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// md_sched: HI/LO owner; sequences MULT/MULTU/DIV/DIVU over fixed latency.
// Ports: clk, reset (async, active-low), md (slave: start/op/a/b/flush/d_is_md in; busy/stall_req/done/hi/lo out).
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_sched_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic [31:0]   hi_r, lo_r;
  logic          busy_r, done_r;

  logic          is_mul, is_div, is_mthi, is_mtlo;
  logic          na, nb;
  logic [31:0]   ua, ub, dvs, uq, ur, q, r;
  logic [63:0]   prod;
  logic [31:0]   res_hi, res_lo;

  assign is_mul  = (md.op[2:1] == 2'b00);
  assign is_div  = (md.op[2:1] == 2'b01);
  assign is_mthi = (md.op == 3'b100);
  assign is_mtlo = (md.op == 3'b101);

  // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN.
  always_comb begin
    na  = (md.op == 3'b010) & md.a[31];
    nb  = (md.op == 3'b010) & md.b[31];
    ua  = na ? -md.a : md.a;
    ub  = nb ? -md.b : md.b;
    dvs = (md.b == 32'd0) ? 32'd1 : ub;
    uq  = ua / dvs;
    ur  = ua % dvs;
    q   = (na ^ nb) ? -uq : uq;
    r   = na ? -ur : ur;
    if (md.op[0])
      prod = {32'd0, md.a} * {32'd0, md.b};
    else
      prod = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
  end

  // Divide by zero re-commits the current HI/LO.
  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_hi = (md.b == 32'd0) ? hi_r : r;
      res_lo = (md.b == 32'd0) ? lo_r : q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (md.start && !md.flush) begin
            unique case (1'b1)
              is_mul, is_div: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= is_mul ? CW'(MULT_CYCLES - 1)
                                  : CW'(DIV_CYCLES - 1);
                state   <= RUN;
                busy_r  <= 1'b1;
              end
              is_mthi: hi_r <= md.a;
              is_mtlo: lo_r <= md.a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (md.flush) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (cnt == '0) begin
            hi_r   <= pend_hi;
            lo_r   <= pend_lo;
            done_r <= 1'b1;
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy      = busy_r;
  assign md.done      = done_r;
  assign md.hi        = hi_r;
  assign md.lo        = lo_r;
  assign md.stall_req = md.d_is_md & (md.start | busy_r);

endmodule
